// File: rtl/inv_round_engine.sv
// Iterative AES inverse cipher: one inverse round per clock, round keys fetched by index.
// Latency: out_valid in the NR+1-th cycle after the accept cycle; one block per NR+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module inv_round_engine #(
    parameter int NK__KEY_LENGTH           = 8,
    parameter int NR__ROUNDS               = 14,
    parameter int NB__BLOCK_LENGTH_IN_TEXT = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [32*NB__BLOCK_LENGTH_IN_TEXT-1:0] ciphertext_in,
    output logic [3:0]                            key_idx_out,
    input  logic [32*NB__BLOCK_LENGTH_IN_TEXT-1:0] round_key_in,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [32*NB__BLOCK_LENGTH_IN_TEXT-1:0] plaintext_out,
    output logic                                  busy
);
    localparam int NB = NB__BLOCK_LENGTH_IN_TEXT;
    localparam int W  = 32 * NB;
    localparam logic [3:0] NR4 = 4'(NR__ROUNDS);

    if (NR__ROUNDS != NK__KEY_LENGTH + 6) begin : g_param_check
        $error("inv_round_engine: NR__ROUNDS must equal NK__KEY_LENGTH + 6");
    end

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

    fsm_t         fsm;
    logic [3:0]   rnd;
    logic [W-1:0] state;
    logic [W-1:0] inv_sub_shift;
    logic [W-1:0] added;
    logic [W-1:0] mixed;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] p;
        logic [7:0] m;
        p = 8'h00;
        m = a;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) p = p ^ m;
            m = xtime(m);
        end
        return p;
    endfunction

    // Column bytes are row 0 at the MSB end.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    endfunction

    // Byte (r,c) lives at bits [W-1-8*(4c+r) -: 8]; row r rotates right by r columns.
    always_comb begin
        inv_sub_shift = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                inv_sub_shift[W-1-8*(4*c+r) -: 8] =
                    INV_SBOX[state[W-1-8*(4*((c + 4*NB - r) % NB)+r) -: 8]];
            end
        end
    end

    assign added = inv_sub_shift ^ round_key_in;

    always_comb begin
        mixed = '0;
        for (int c = 0; c < NB; c++) begin
            mixed[W-1-32*c -: 32] = inv_mix_col(added[W-1-32*c -: 32]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm   <= IDLE;
            rnd   <= NR4;
            state <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state <= ciphertext_in ^ round_key_in;
                        rnd   <= NR4 - 4'd1;
                        fsm   <= (NR__ROUNDS == 1) ? FINAL : ROUND;
                    end
                end
                ROUND: begin
                    state <= mixed;
                    if (rnd == 4'd1) fsm <= FINAL;
                    else             rnd <= rnd - 4'd1;
                end
                FINAL: begin
                    state <= added;
                    fsm   <= DONE;
                    rnd   <= NR4;
                end
                DONE: begin
                    if (out_ready) fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    // rnd rests at NR outside ROUND/FINAL, so IDLE and DONE both present NR.
    assign key_idx_out   = (fsm == FINAL) ? 4'd0 : rnd;
    assign in_ready      = (fsm == IDLE);
    assign out_valid     = (fsm == DONE);
    assign busy          = (fsm != IDLE);
    assign plaintext_out = state;

endmodule
